// File: rtl/ieee754_adder_seq.sv
// Multi-cycle IEEE754 add/subtract with round-to-nearest-even, specials and status flags.
// Latency: fixed 4 cycles from accepted start to the done pulse (IDLE->ALIGN->ADDSUB->NORM->ROUND).
// Backpressure: start is ignored while busy; a start during the done cycle is accepted.
// Ports: clk/rst (sync, active-high); start, a, b, sub in; busy, done, result and
//        overflow/underflow/invalid/inexact out. Result and flags are registered and
//        held until the next done.
module ieee754_adder_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   sub,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   invalid,
  output logic                   inexact
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 4;   // hidden + fraction + G,R,S
  localparam int EW = EXP_W + 2;   // signed working exponent, room for carry and lzc underflow
  localparam logic [EXP_W-1:0]        SH_MAX = EXP_W'(MAN_W + 3);
  localparam logic signed [EW-1:0]    EMAX   = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]            QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADDSUB, S_NORM, S_ROUND} state_t;
  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} spec_t;

  state_t                 state_q;
  spec_t                  spec_q, spec_d;
  logic                   spec_sign_q, spec_sign_d;
  logic [W-1:0]           a_q, b_q;
  logic                   sign_q, eff_sub_q;
  logic signed [EW-1:0]   exp_q;
  logic [MW-1:0]          mx_q, my_q, nm_q;
  logic [MW:0]            sum_q;
  logic                   zero_q;
  logic                   busy_q, done_q, ovf_q, unf_q, inv_q, inx_q;
  logic [W-1:0]           result_q;

  // Leading-zero count; the last hit in the upward scan is the most significant set bit.
  function automatic logic [EW-1:0] lzc(input logic [MW-1:0] v);
    logic [EW-1:0] n;
    n = EW'(MW);
    for (int i = 0; i < MW; i++) if (v[i]) n = EW'(MW - 1 - i);
    return n;
  endfunction

  // ALIGN: order operands by magnitude, align the smaller, classify specials.
  logic [EXP_W-1:0] ea, eb, ex, ey, dsh;
  logic [MAN_W-1:0] fa, fb, fx, fy;
  logic [W-2:0]     mag_a, mag_b;
  logic             sa, sb, sx, swap, nan_a, nan_b, inf_a, inf_b, za, zb, lost;
  logic [MW-1:0]    mx_d, my_full, my_sh, my_d;

  always_comb begin
    sa = a_q[W-1]; ea = a_q[W-2:MAN_W]; fa = a_q[MAN_W-1:0];
    sb = b_q[W-1]; eb = b_q[W-2:MAN_W]; fb = b_q[MAN_W-1:0];
    za = (ea == '0); zb = (eb == '0);
    // Denormals count as zero, so their fraction must not win the magnitude compare.
    mag_a = za ? '0 : a_q[W-2:0];
    mag_b = zb ? '0 : b_q[W-2:0];
    swap  = mag_b > mag_a;
    sx = swap ? sb : sa;
    ex = swap ? eb : ea;  ey = swap ? ea : eb;
    fx = swap ? fb : fa;  fy = swap ? fa : fb;
    mx_d    = (ex == '0) ? '0 : {1'b1, fx, 3'b000};
    my_full = (ey == '0) ? '0 : {1'b1, fy, 3'b000};
    dsh = ex - ey;
    if (dsh > SH_MAX) dsh = SH_MAX;
    my_sh = my_full >> dsh;
    lost  = |(my_full & ~({MW{1'b1}} << dsh));
    my_d  = {my_sh[MW-1:1], my_sh[0] | lost};

    nan_a = (&ea) & (|fa);  inf_a = (&ea) & ~(|fa);
    nan_b = (&eb) & (|fb);  inf_b = (&eb) & ~(|fb);
    spec_d = SP_NONE; spec_sign_d = 1'b0;
    if (nan_a | nan_b | (inf_a & inf_b & (sa ^ sb))) spec_d = SP_NAN;
    else if (inf_a) begin spec_d = SP_INF;  spec_sign_d = sa;      end
    else if (inf_b) begin spec_d = SP_INF;  spec_sign_d = sb;      end
    else if (za & zb) begin spec_d = SP_ZERO; spec_sign_d = sa & sb; end
  end

  // ADDSUB: X >= Y in magnitude, so the difference never goes negative.
  logic [MW:0] sum_d;
  always_comb begin
    sum_d = eff_sub_q ? ({1'b0, mx_q} - {1'b0, my_q}) : ({1'b0, mx_q} + {1'b0, my_q});
  end

  // NORM: carry-out shifts right (lost bit folded into sticky), otherwise left by lzc.
  logic [EW-1:0]        lz;
  logic [MW-1:0]        nm_d;
  logic signed [EW-1:0] exp_n_d;
  always_comb begin
    lz = lzc(sum_q[MW-1:0]);
    if (sum_q[MW]) begin
      nm_d    = {sum_q[MW:2], sum_q[1] | sum_q[0]};
      exp_n_d = exp_q + EW'(1);
    end else begin
      nm_d    = sum_q[MW-1:0] << lz;
      exp_n_d = exp_q - $signed(lz);
    end
  end

  // ROUND: RNE, renormalise on mantissa carry-out, then resolve specials and range.
  logic                 g, r, s, rup;
  logic [MAN_W+1:0]     mr;
  logic signed [EW-1:0] exp_r;
  logic [MAN_W-1:0]     frac_r;
  logic [W-1:0]         res_d;
  logic                 ovf_d, unf_d, inv_d, inx_d;
  always_comb begin
    g = nm_q[2]; r = nm_q[1]; s = nm_q[0];
    rup    = g & (r | s | nm_q[3]);
    mr     = {1'b0, nm_q[MW-1:3]} + {{(MAN_W+1){1'b0}}, rup};
    exp_r  = mr[MAN_W+1] ? exp_q + EW'(1) : exp_q;
    frac_r = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
    res_d  = {sign_q, exp_r[EXP_W-1:0], frac_r};
    ovf_d = 1'b0; unf_d = 1'b0; inv_d = 1'b0; inx_d = g | r | s;
    case (spec_q)
      SP_NAN:  begin res_d = QNAN; inv_d = 1'b1; inx_d = 1'b0; end
      SP_INF:  begin res_d = {spec_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}; inx_d = 1'b0; end
      SP_ZERO: begin res_d = {spec_sign_q, {(W-1){1'b0}}}; inx_d = 1'b0; end
      default: begin
        if (zero_q) begin
          res_d = '0; inx_d = 1'b0;               // exact cancellation is +0
        end else if (exp_q[EW-1] || (exp_q == '0)) begin
          res_d = {sign_q, {(W-1){1'b0}}}; unf_d = 1'b1; inx_d = 1'b1;
        end else if (exp_r >= EMAX) begin
          res_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}; ovf_d = 1'b1; inx_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE; busy_q <= 1'b0; done_q <= 1'b0; result_q <= '0;
      ovf_q <= 1'b0; unf_q <= 1'b0; inv_q <= 1'b0; inx_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          a_q <= a; b_q <= b ^ {sub, {(W-1){1'b0}}};
          busy_q <= 1'b1; state_q <= S_ALIGN;
        end
        S_ALIGN: begin
          sign_q <= sx; eff_sub_q <= sa ^ sb; exp_q <= $signed({2'b00, ex});
          mx_q <= mx_d; my_q <= my_d; spec_q <= spec_d; spec_sign_q <= spec_sign_d;
          state_q <= S_ADDSUB;
        end
        S_ADDSUB: begin sum_q <= sum_d; state_q <= S_NORM; end
        S_NORM: begin
          nm_q <= nm_d; exp_q <= exp_n_d; zero_q <= (sum_q == '0); state_q <= S_ROUND;
        end
        S_ROUND: begin
          result_q <= res_d; ovf_q <= ovf_d; unf_q <= unf_d; inv_q <= inv_d; inx_q <= inx_d;
          busy_q <= 1'b0; done_q <= 1'b1; state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign invalid   = inv_q;
  assign inexact   = inx_q;
endmodule

// File: tb/tb_ieee754_adder_seq.sv
// Directed testbench for ieee754_adder_seq (binary32 defaults).
module tb_ieee754_adder_seq;
  logic        clk, rst, start, sub;
  logic [31:0] a, b, result;
  logic        busy, done, overflow, underflow, invalid, inexact;
  int          n_tests, n_fail;

  ieee754_adder_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sub(sub),
    .busy(busy), .done(done), .result(result), .overflow(overflow),
    .underflow(underflow), .invalid(invalid), .inexact(inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All stimulus and sampling happens 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  // Launches one operation and waits (bounded) for done; returns what the DUT showed at done.
  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                       output logic [31:0] r, output logic [3:0] f, output int lat);
    a = ia; b = ib; sub = isub; start = 1'b1;
    step();
    start = 1'b0; lat = 0;
    while (!done && lat < 20) begin step(); lat++; end
    r = result; f = {overflow, underflow, invalid, inexact};
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    step(); step();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
    n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h want=00000000", result); end
    n_tests++; if ({overflow, underflow, invalid, inexact} !== 4'b0) begin n_fail++;
      $display("FAIL reset_flags got=%b want=0000", {overflow, underflow, invalid, inexact}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int lat, bcnt;
    a = 32'h40980000; b = 32'h40080000; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0; lat = 0; bcnt = 0;
    while (!done && lat < 20) begin if (busy) bcnt++; step(); lat++; end
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL basic_latency got=%0d want=4", lat); end
    n_tests++; if (bcnt !== 4) begin n_fail++; $display("FAIL basic_busy_cycles got=%0d want=4", bcnt); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done got=%b want=0", busy); end
    n_tests++; if (result !== 32'h40DC0000) begin n_fail++; $display("FAIL basic_result got=%h want=40dc0000", result); end
    n_tests++; if ({overflow, underflow, invalid, inexact} !== 4'b0) begin n_fail++;
      $display("FAIL basic_flags got=%b want=0000", {overflow, underflow, invalid, inexact}); end
    step();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got=%b want=0", done); end
    n_tests++; if (result !== 32'h40DC0000) begin n_fail++; $display("FAIL basic_hold got=%h want=40dc0000", result); end
  endtask

  // Directed vectors: a, b, sub, expected result, expected {ovf,unf,inv,inx}.
  task automatic test_vectors();
    logic [31:0] va[13], vb[13], vr[13], r;
    logic        vs[13];
    logic [3:0]  vf[13], f;
    int          lat;
    va = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3FFFFFFF, 32'h7F7FFFFF, 32'h7F800000,
           32'h7FC00001, 32'hFF800000, 32'h00000000, 32'h80000000, 32'h00800000, 32'h40000000};
    vb = '{32'hBF000000, 32'h3F800000, 32'h33800000, 32'h33C00000, 32'h33800000, 32'h7F7FFFFF, 32'hFF800000,
           32'h3F800000, 32'h3F800000, 32'h80000000, 32'h80000000, 32'h00800001, 32'h3F800000};
    vs = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vr = '{32'h3F000000, 32'h00000000, 32'h3F800000, 32'h3F800001, 32'h40000000, 32'h7F800000, 32'h7FC00000,
           32'h7FC00000, 32'hFF800000, 32'h00000000, 32'h80000000, 32'h80000000, 32'h3F800000};
    vf = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b1001, 4'b0010,
           4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0101, 4'b0000};
    for (int i = 0; i < 13; i++) begin
      do_op(va[i], vb[i], vs[i], r, f, lat);
      n_tests++; if (r !== vr[i] || f !== vf[i] || lat !== 4) begin n_fail++;
        $display("FAIL vec%0d got=%h flags=%b lat=%0d want=%h flags=%b lat=4", i, r, f, lat, vr[i], vf[i]); end
    end
    step();
  endtask

  task automatic test_back_to_back();
    int lat, extra;
    a = 32'h40980000; b = 32'h40080000; sub = 1'b0; start = 1'b1;
    step();
    // Operands change while busy with start still high: must be ignored until the done cycle.
    a = 32'h3F800000; b = 32'hBF000000; lat = 0;
    while (!done && lat < 20) begin step(); lat++; end
    n_tests++; if (lat !== 4 || result !== 32'h40DC0000) begin n_fail++;
      $display("FAIL b2b_first got=%h lat=%0d want=40dc0000 lat=4", result, lat); end
    step();
    n_tests++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++;
      $display("FAIL b2b_accept_in_done got busy=%b done=%b want busy=1 done=0", busy, done); end
    start = 1'b0; lat = 1;
    while (!done && lat < 20) begin
      n_tests++; if (result !== 32'h40DC0000) begin n_fail++;
        $display("FAIL b2b_hold got=%h want=40dc0000", result); end
      step(); lat++;
    end
    n_tests++; if (lat !== 5 || result !== 32'h3F000000) begin n_fail++;
      $display("FAIL b2b_second got=%h spacing=%0d want=3f000000 spacing=5", result, lat); end
    extra = 0;
    for (int i = 0; i < 6; i++) begin step(); if (done) extra++; end
    n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL b2b_no_third got=%0d dones want=0", extra); end
  endtask

  task automatic test_reset_mid();
    int seen, lat;
    logic [31:0] r;
    logic [3:0]  f;
    a = 32'h40980000; b = 32'h40080000; sub = 1'b0; start = 1'b1;
    step();                 // accepted: ALIGN
    start = 1'b0;
    step();                 // ADDSUB
    step();                 // NORM
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++;
      $display("FAIL rstmid_state got busy=%b done=%b want 0 0", busy, done); end
    n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL rstmid_result got=%h want=00000000", result); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin step(); if (done) seen++; end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL rstmid_no_done got=%0d want=0", seen); end
    do_op(32'h3F800000, 32'h33C00000, 1'b0, r, f, lat);
    n_tests++; if (r !== 32'h3F800001 || f !== 4'b0001 || lat !== 4) begin n_fail++;
      $display("FAIL rstmid_recover got=%h flags=%b lat=%0d want=3f800001 flags=0001 lat=4", r, f, lat); end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
